nibble_serial_adder: RTL and testbench

Nibble-serial wide adder controller that computes `A + B + cin` for `4*NIBBLES`-bit operands using a single 4-bit ripple-carry slice. It processes one nibble per cycle, least significant nibble first, and registers the carry between nibbles. It sits directly upstream of the 4-bit adder slice and feeds it: it accepts wide operands over a valid/ready handshake, drives the slice, collects the slice's sum and carry-out, and presents the full result over a second valid/ready handshake.

---
 rtl/nsa_pkg.sv | 17 +
 rtl/nib_add4.sv | 22 ++
 rtl/nibble_serial_adder.sv | 111 +++++++++++
 tb/tb_nibble_serial_adder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package nsa_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/nib_add4.sv
// Combinational 4-bit ripple-carry slice built from four chained full-adder cells.
module nib_add4
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
    end

    assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder computing A + B + cin one nibble per cycle through a single 4-bit slice,
// with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIB_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic         busy
);

    localparam int                IDX_W = $clog2(NIBBLES) + 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBBLES - 1);

    nsa_state_t       state_q;
    logic [W-1:0]     a_q, b_q, sum_q;
    logic [W-1:0]     a_d, b_d, sum_d;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [NIB_W-1:0] sl_s;
    logic             sl_co;

    nib_add4 u_slice (
        .a  (a_q[NIB_W-1:0]),
        .b  (b_q[NIB_W-1:0]),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    // Each new slice result enters at the top so nibble 0 ends up in the LSBs.
    assign a_d   = a_q >> NIB_W;
    assign b_d   = b_q >> NIB_W;
    assign sum_d = (sum_q >> NIB_W) | (W'(sl_s) << (W - NIB_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        carry_q    <= in_cin;
                        sum_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ADD;
                    end
                end
                ADD: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= sl_co;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Partial sums and carries are hidden until the result is complete.
    assign out_sum   = out_valid_q ? sum_q : '0;
    assign out_cout  = out_valid_q ? carry_q : 1'b0;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against an arithmetic reference.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [W-1:0] in_a, in_b, out_sum;

    logic         x_in_valid, x_in_ready, x_in_cin, x_out_valid, x_out_ready, x_out_cout, x_busy;
    logic [3:0]   x_in_a, x_in_b, x_out_sum;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int hs_cnt    = 0;
    int acc_cyc   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_a(x_in_a), .in_b(x_in_b), .in_cin(x_in_cin),
        .out_valid(x_out_valid), .out_ready(x_out_ready),
        .out_sum(x_out_sum), .out_cout(x_out_cout), .busy(x_busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the NIBBLES=4 instance, called #1 after a rising edge.
    task automatic op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int stall, input string tag);
        logic [W:0] ref_res;
        int         lat;
        ref_res = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(N));
        check({tag, ".sum"},  32'(out_sum),  32'(ref_res[W-1:0]));
        check({tag, ".cout"}, 32'(out_cout), 32'(ref_res[W]));
        for (int i = 0; i < stall; i++) begin
            in_a = W'($urandom);
            @(posedge clk); #1;
            check({tag, ".hold"}, {13'd0, out_valid, in_ready, busy, out_cout, out_sum},
                  {13'd0, 1'b1, 1'b0, 1'b1, ref_res[W], ref_res[W-1:0]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".ret"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    initial begin
        int a_prev, h0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        x_in_valid = 1'b0; x_in_a = '0; x_in_b = '0; x_in_cin = 1'b0; x_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready",  32'(in_ready),  32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_sum",   32'(out_sum),   32'd0);
        check("rst.out_cout",  32'(out_cout),  32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        op4(16'h1234, 16'h4321, 1'b0, 0, "t1234");
        a_prev = acc_cyc;
        op4(16'hFFFF, 16'h0001, 1'b0, 0, "ripple_b");
        check("spacing", 32'(acc_cyc - a_prev), 32'(N + 2));
        op4(16'hFFFF, 16'h0000, 1'b1, 0, "ripple_cin");
        op4(16'hBEEF, 16'hCAFE, 1'b1, 5, "backpressure");

        x_out_ready = 1'b1;
        check("n1.in_ready", 32'(x_in_ready), 32'd1);
        x_in_valid = 1'b1; x_in_a = 4'hF; x_in_b = 4'h1; x_in_cin = 1'b1;
        @(posedge clk); #1;
        x_in_valid = 1'b0; x_in_a = 4'h0; x_in_b = 4'h0; x_in_cin = 1'b0;
        check("n1.valid_early", 32'(x_out_valid), 32'd0);
        @(posedge clk); #1;
        check("n1.valid", 32'(x_out_valid), 32'd1);
        check("n1.sum",   32'(x_out_sum),   32'h1);
        check("n1.cout",  32'(x_out_cout),  32'd1);
        @(posedge clk); #1;
        check("n1.ret", {30'd0, x_out_valid, x_in_ready}, 32'b01);

        in_valid = 1'b1; in_a = 16'hABCD; in_b = 16'h9876; in_cin = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.outs", {28'd0, out_valid, out_cout, busy, in_ready}, 32'd0);
        check("midrst.sum",  32'(out_sum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst.release", {30'd0, in_ready, out_valid}, 32'b10);
        op4(16'h0001, 16'h0001, 1'b0, 0, "after_rst");

        h0 = hs_cnt;
        for (int k = 0; k < 1000; k++) begin
            int gap, st;
            gap = int'($urandom_range(0, 2));
            st  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            op4(W'($urandom), W'($urandom), 1'($urandom), st, "rand");
        end
        check("rand.handshakes", 32'(hs_cnt - h0), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
